// File: rtl/edsac_pkg.sv
// Shared EDSAC store constants and the tank transfer state type.
package edsac_pkg;
    localparam int MC_LEN         = 36;
    localparam int HALF_MC        = 18;
    localparam int LONG_BITS      = 35;
    localparam int SHORT_BITS     = 17;
    localparam int WORDS_PER_TANK = 16;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} tank_state_e;
endpackage

// File: rtl/tank_timer.sv
// Free-running pulse-interval / minor-cycle counters and slot-start strobe.
module tank_timer #(
    parameter int WORDS  = edsac_pkg::WORDS_PER_TANK,
    parameter int MC_LEN = edsac_pkg::MC_LEN,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [5:0]    pi_cnt,
    output logic [AW-1:0] mc_cnt,
    output logic          slot_start
);
    localparam logic [5:0]    PI_LAST = 6'(MC_LEN - 1);
    localparam logic [AW-1:0] MC_LAST = AW'(WORDS - 1);

    logic [5:0]    pi_q, pi_d;
    logic [AW-1:0] mc_q, mc_d;

    always_comb begin
        pi_d = pi_q + 6'd1;
        mc_d = mc_q;
        if (pi_q == PI_LAST) begin
            pi_d = '0;
            mc_d = (mc_q == MC_LAST) ? '0 : mc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pi_q <= '0;
            mc_q <= '0;
        end else begin
            pi_q <= pi_d;
            mc_q <= mc_d;
        end
    end

    assign pi_cnt     = pi_q;
    assign mc_cnt     = mc_q;
    assign slot_start = (mc_q == addr) && (pi_q == '0);
endmodule

// File: rtl/mem_tank.sv
// One EDSAC mercury tank: 16 recirculating minor cycles, serial read/write
// of long or short words on the p.i. clock.
module mem_tank #(
    parameter int WORDS  = edsac_pkg::WORDS_PER_TANK,
    parameter int MC_LEN = edsac_pkg::MC_LEN,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          req,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic          f1_pos,
    input  logic          f2_pos,
    input  logic          mib,
    output logic          mob,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [5:0]    pi_cnt,
    output logic [AW-1:0] mc_cnt
);
    import edsac_pkg::*;

    localparam logic [5:0] PI_LAST = 6'(MC_LEN - 1);

    tank_state_e state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          f1_q, f2_q, rd_q, wr_q, err_q;
    logic [WORDS-1:0][MC_LEN-1:0] mem_q;
    logic          slot_start, accept, xfer, in_win;

    tank_timer #(.WORDS(WORDS), .MC_LEN(MC_LEN), .AW(AW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr_q),
        .pi_cnt    (pi_cnt),
        .mc_cnt    (mc_cnt),
        .slot_start(slot_start)
    );

    assign accept = req & sel & (state_q == IDLE);

    always_comb begin
        if (f1_q)
            in_win = pi_cnt < 6'(LONG_BITS);
        else if (f2_q)
            in_win = (pi_cnt >= 6'(HALF_MC)) && (pi_cnt < 6'(HALF_MC + SHORT_BITS));
        else
            in_win = pi_cnt < 6'(SHORT_BITS);
    end

    // The slot-start cycle itself carries p.i. 0, so WAIT already transfers
    // in that cycle; XFER then covers p.i. 1..35.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept && (rd ^ wr)) state_d = WAIT;
            end
            WAIT: begin
                if (slot_start) begin
                    xfer    = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                xfer = 1'b1;
                if (pi_cnt == PI_LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept & ~(rd ^ wr);
            if (accept) begin
                addr_q <= addr;
                f1_q   <= f1_pos;
                f2_q   <= f2_pos;
                rd_q   <= rd;
                wr_q   <= wr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_q <= '0;
        else if (xfer && wr_q && in_win)
            mem_q[addr_q][pi_cnt] <= mib;
    end

    assign mob = xfer & rd_q & in_win & mem_q[addr_q][pi_cnt];
    assign err = err_q;
endmodule

// File: tb/tb_mem_tank.sv
// Self-checking bench for mem_tank against an absolute-time reference model.
module tb_mem_tank;
    logic       clk = 1'b0;
    logic       rst, sel, req, rd, wr, f1_pos, f2_pos, mib;
    logic [3:0] addr;
    logic       mob, busy, done, err;
    logic [5:0] pi_cnt;
    logic [3:0] mc_cnt;

    mem_tank #(.WORDS(16), .MC_LEN(36), .AW(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .req(req), .rd(rd), .wr(wr),
        .addr(addr), .f1_pos(f1_pos), .f2_pos(f2_pos), .mib(mib),
        .mob(mob), .busy(busy), .done(done), .err(err),
        .pi_cnt(pi_cnt), .mc_cnt(mc_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time is an absolute cycle count since reset release.
    bit [35:0] mref [16];
    int        tcyc, acc_t, xs, err_t, done_seen_t;
    bit        pend;
    bit        m_rd, m_wr, m_f1, m_f2;
    int        m_addr;
    bit [35:0] wdata, rword;

    function automatic bit in_window(bit f1, bit f2, int pi);
        if (f1) return pi <= 34;
        if (f2) return (pi >= 18) && (pi <= 34);
        return pi <= 16;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, tcyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mref[i] = '0;
        tcyc = 0; pend = 0; err_t = -1; acc_t = 0; xs = 0;
    endtask

    task automatic tick();
        int pi, mc, d;
        bit xf, win, e_busy, e_done, e_err, e_mob;
        pi = tcyc % 36;
        mc = (tcyc / 36) % 16;
        xf = pend && (tcyc >= xs) && (tcyc < xs + 36);
        win = xf && in_window(m_f1, m_f2, pi);
        mib = (win && m_wr) ? wdata[pi] : 1'($urandom);
        e_busy = pend && (tcyc > acc_t);
        e_done = pend && (tcyc == xs + 36);
        e_err  = (tcyc == err_t);
        e_mob  = win && m_rd && mref[m_addr][pi];
        @(negedge clk);
        chk("pi_cnt", 64'(pi_cnt), 64'(pi));
        chk("mc_cnt", 64'(mc_cnt), 64'(mc));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("err", 64'(err), 64'(e_err));
        chk("mob", 64'(mob), 64'(e_mob));
        if (win && m_rd) rword[pi] = mob;
        if (done === 1'b1) done_seen_t = tcyc;
        @(posedge clk);
        if (win && m_wr) mref[m_addr][pi] = mib;
        if (e_done) pend = 0;
        if (req && sel && !e_busy) begin
            if (rd ^ wr) begin
                pend = 1; acc_t = tcyc;
                m_rd = rd; m_wr = wr; m_f1 = f1_pos; m_f2 = f2_pos; m_addr = int'(addr);
                d = (m_addr * 36 - (tcyc % 576) + 576) % 576;
                if (d == 0) d = 576;
                xs = tcyc + d;
            end else begin
                err_t = tcyc + 1;
            end
        end
        tcyc++;
        #1;
    endtask

    task automatic issue(bit s, bit r, bit w, int a, bit f1, bit f2);
        sel = s; req = 1'b1; rd = r; wr = w; addr = 4'(a); f1_pos = f1; f2_pos = f2;
        tick();
        req = 1'b0; sel = 1'b0; rd = 1'($urandom); wr = 1'($urandom);
        addr = 4'($urandom); f1_pos = 1'($urandom); f2_pos = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1300 && (pend || busy === 1'b1); i++) tick();
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_mob", 64'(mob), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_pi", 64'(pi_cnt), 64'd0);
        chk("rst_mc", 64'(mc_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; req = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; f1_pos = 1'b0; f2_pos = 1'b0; mib = 1'b0;
        wdata = '0; rword = '0; done_seen_t = -1;
        model_clear();
        @(posedge clk);
        do_reset();

        // 1: idle, counters wrap
        for (int i = 0; i < 600; i++) tick();

        // 2: long write/read at addr 3
        wdata = 36'h5_5555_5555;
        issue(1, 0, 1, 3, 1, 0);
        wait_idle();
        rword = '0;
        issue(1, 1, 0, 3, 1, 0);
        wait_idle();
        chk("t2_long_word", 64'(rword[34:0]), 64'h5_5555_5555);

        // 3: short write to second half, read both halves
        wdata = 36'h1FFFF << 18;
        issue(1, 0, 1, 7, 0, 1);
        wait_idle();
        rword = '1;
        issue(1, 1, 0, 7, 0, 0);
        wait_idle();
        chk("t3_first_half", 64'(rword[16:0]), 64'd0);
        rword = '0;
        issue(1, 1, 0, 7, 0, 1);
        wait_idle();
        chk("t3_second_half", 64'(rword[34:18]), 64'h1FFFF);

        // 4: acceptance coinciding with slot start waits a full major cycle
        for (int i = 0; i < 700 && (tcyc % 576) != 180; i++) tick();
        begin
            int acc;
            acc = tcyc;
            done_seen_t = -1;
            issue(1, 1, 0, 5, 1, 0);
            wait_idle();
            chk("t4_latency", 64'(done_seen_t - acc), 64'd612);
        end

        // 5: illegal request, and request while busy
        issue(1, 1, 1, 4, 1, 0);
        tick();
        issue(1, 0, 0, 4, 0, 0);
        tick(); tick();
        rword = '0;
        issue(1, 1, 0, 3, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        wdata = '0;
        issue(1, 0, 1, 3, 1, 0);
        wait_idle();
        chk("t5_intact", 64'(rword[34:0]), 64'h5_5555_5555);

        // 6: reset in the middle of a write
        wdata = '1;
        issue(1, 0, 1, 2, 1, 0);
        for (int i = 0; i < 1300 && !(pend && tcyc >= xs + 10); i++) tick();
        chk("t6_busy_before_rst", 64'(busy), 64'd1);
        do_reset();
        rword = '1;
        issue(1, 1, 0, 2, 1, 0);
        wait_idle();
        chk("t6_cleared", 64'(rword[34:0]), 64'd0);

        // Random operations over a few slots, including deselected requests
        for (int n = 0; n < 10; n++) begin
            int a;
            bit s, r, w;
            case ($urandom_range(2)) 0: a = 1; 1: a = 4; default: a = 9; endcase
            s = ($urandom_range(4) != 0);
            r = 1'($urandom);
            w = 1'($urandom);
            wdata = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            issue(s, r, w, a, 1'($urandom), 1'($urandom));
            tick();
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_tank.md
Name: mem_tank

Overview:
- Behavioural model of one EDSAC mercury memory tank: a recirculating serial store of 16 minor cycles × 36 pulse intervals (p.i.).
- On a read request it serialises the addressed long or short word onto its tank output bus. This bus is one of the inputs OR-ed into the rack output bus, and from there into the transfer unit.
- On a write request it captures the serial memory input bus (mib) into the addressed slot.
- Tanks sharing a rack are reset together, so their p.i./minor-cycle counters stay in lockstep.

Parameters:
WORDS, 16, minor cycles (long-word slots) per tank
MC_LEN, 36, pulse intervals per minor cycle
AW, 4, address width; must satisfy 2**AW == WORDS

Ports:
clk  input  1  pulse-interval clock; one bit per cycle
rst  input  1  asynchronous, active-high reset
sel  input  1  tank selected by the rack address decoder
req  input  1  start-transfer strobe; sampled only when busy=0
rd  input  1  read (tank -> mob)
wr  input  1  write (mib -> tank)
addr  input  AW  minor-cycle slot number
f1_pos  input  1  high: long word (35 bits)
f2_pos  input  1  short word only; high: second half of minor cycle
mib  input  1  serial memory input bus, LSB first
mob  output  1  serial tank output bus, LSB first; 0 when not reading
busy  output  1  request in progress
done  output  1  one-cycle pulse after the last p.i. of a transfer
err  output  1  one-cycle pulse on an illegal request
pi_cnt  output  6  current p.i. position, 0..MC_LEN-1
mc_cnt  output  AW  current minor cycle, 0..WORDS-1

Behaviour:
- Reset values:
  - mob=0, busy=0, done=0, err=0, pi_cnt=0, mc_cnt=0.
  - State = IDLE.
  - All 576 storage bits = 0.
  - Reset mid-transfer aborts the transfer and clears the contents; done is not pulsed.
- Counters:
  - pi_cnt increments every clk and wraps 35 -> 0.
  - mc_cnt increments on that wrap and wraps WORDS-1 -> 0.
  - Both run free and are independent of requests.
- Storage is indexed [mc][pi]; a bit recirculates unchanged unless written.
- Word windows:
  - Long word (f1_pos=1): p.i. 0..34. f2_pos is ignored.
  - Short word, first half (f1_pos=0, f2_pos=0): p.i. 0..16.
  - Short word, second half (f1_pos=0, f2_pos=1): p.i. 18..34.
  - p.i. 35 is the inter-word gap. It is never driven on mob and never written.
  - p.i. 17 is written or read only as part of a long word.
- Request acceptance:
  - A request is accepted in a cycle with req & sel & ~busy.
  - addr, f1_pos, f2_pos, rd and wr are latched at acceptance.
  - rd & wr, or ~rd & ~wr, is illegal: err pulses the next cycle, the request is dropped and busy stays 0.
  - req while busy=1 is ignored, with no err.
  - req with sel=0 is ignored.
- FSM:
  - IDLE: on legal acceptance -> WAIT; busy=1 from the next cycle.
  - WAIT -> XFER at the first cycle strictly after acceptance with mc_cnt==addr_l and pi_cnt==0. An acceptance that coincides with that point waits a full major cycle (576 cycles).
  - XFER:
    - Lasts exactly MC_LEN cycles, pi 0..35.
    - Read: mob = stored[addr_l][pi_cnt] combinationally in the same cycle, for p.i. inside the window. mob=0 outside the window.
    - Write: stored[addr_l][pi_cnt] <= mib sampled in that cycle, for p.i. inside the window. Bits outside the window (including the other short half) are preserved.
    - After pi 35 -> DONE.
  - DONE: done=1 and busy=1 for one cycle -> IDLE. A new req is accepted from the cycle after DONE.
- Latency: acceptance to first data bit is 1..576 cycles; acceptance to done is that value plus 36.
- Read-after-write to the same slot returns the new data on the next visit to that slot.
- mob is 0 at all times other than read windows, so the rack OR-bus is safe.

Decomposition:
- Shared package edsac_pkg:
  - constants MC_LEN=36, HALF_MC=18, LONG_BITS=35, SHORT_BITS=17, WORDS_PER_TANK=16.
  - state enum {IDLE, WAIT, XFER, DONE}.
- One natural sub-module: tank_timer. It holds the free-running pi_cnt/mc_cnt pair plus a slot_start strobe (mc_cnt==addr & pi_cnt==0). It is reused later by the rack-level address decoder to keep all tanks aligned.

Test Plan:
1. Reset, then run 600 cycles idle -> mob=0 throughout, busy=0, and pi_cnt/mc_cnt wrap at 35 and 15 respectively.
2. Write long word 0x5_5555_5555 (35 bits) to addr 3, then read addr 3 long -> mob reproduces the pattern LSB first at p.i. 0..34 of minor cycle 3; mob=0 at p.i. 35; done pulses one cycle after p.i. 35.
3. Write short 0x1FFFF to addr 7 second half, then read addr 7 first half -> 0 (untouched); read addr 7 second half -> 0x1FFFF at p.i. 18..34.
4. Issue req when mc_cnt=5 and pi_cnt=0 with addr=5 -> transfer starts 576 cycles later, not immediately.
5. Assert req with rd=wr=1 -> err pulses once and busy stays 0. Assert req during busy -> ignored, and the original transfer completes intact.
6. Assert rst midway through a write to addr 2 -> all outputs return to reset values and a subsequent read of addr 2 returns all zeros.
